// File: rtl/sd_block_pkg.sv
// Shared definitions for the SD block port: register map, STATUS bit positions, FSM states.
package sd_block_pkg;

  localparam logic [31:0] OFF_SECTOR  = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL    = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
  localparam logic [31:0] OFF_RELEASE = 32'h0000_000C;
  localparam logic [31:0] OFF_BUF     = 32'h0000_0200;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL0   = 1;
  localparam int ST_FULL1   = 2;
  localparam int ST_OVR     = 3;
  localparam int ST_REM_LSB = 8;

  localparam int REL_BANK0 = 0;
  localparam int REL_BANK1 = 1;
  localparam int REL_OVR   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FILL  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  // Sector numbers wrap modulo 2^32.
  function automatic logic [31:0] sector_inc(input logic [31:0] s);
    return s + 32'd1;
  endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// Little-endian byte-to-word assembler; flags the last byte of a 4*BLOCK_WORDS-byte block.
module sd_byte_packer
  import sd_block_pkg::*;
#(
  parameter int BLOCK_WORDS = 128,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             stb_i,
  input  logic [7:0]       byte_i,
  output logic [31:0]      word_o,
  output logic             word_vld_o,
  output logic [IDX_W-1:0] word_idx_o,
  output logic             blk_done_o
);

  localparam int CNT_W = IDX_W + 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      sr_q;

  // Word and done flag are combinational with the 4th strobe so the write lands on that edge.
  assign word_o     = {byte_i, sr_q};
  assign word_vld_o = stb_i && (cnt_q[1:0] == 2'b11);
  assign word_idx_o = cnt_q[CNT_W-1:2];
  assign blk_done_o = stb_i && (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (stb_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (stb_i) begin
      sr_q <= {byte_i, sr_q[23:8]};
    end
  end

endmodule

// File: rtl/sd_block_port.sv
// Memory-mapped multi-block SD reader with ping-pong buffering in front of the SPI byte engine.
// Optional interrupt output enabled by defining SD_BLOCK_PORT_IRQ_EN.
module sd_block_port
  import sd_block_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0250,
  parameter int          BLOCK_WORDS  = 128,
  parameter int          MAX_BLOCKS_W = 8
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output wire  [31:0] wReadData,
  output logic        oEngRd,
  output logic [31:0] oEngAddr,
  input  logic        iEngBusy,
  input  logic [7:0]  iEngByte,
  input  logic        iEngValid
`ifdef SD_BLOCK_PORT_IRQ_EN
  ,
  output logic        oIRQ
`endif
);

  localparam int          IDX_W   = $clog2(BLOCK_WORDS);
  localparam int          BIDX_W  = IDX_W + 1;
  localparam logic [31:0] BUF_END = OFF_BUF + 32'(8 * BLOCK_WORDS);

  state_e                  state_q;
  logic [31:0]             sector_q;
  logic [MAX_BLOCKS_W-1:0] rem_q;
  logic                    bank_q;
  logic [1:0]              full_q, full_d;
  logic                    ovr_q, ovr_d;
  logic [31:0]             mem_q [0:2*BLOCK_WORDS-1];

  logic [31:0]      off, buf_off, rdata, status_w;
  logic             reg_hit, buf_hit;
  logic [BIDX_W-1:0] buf_idx;
  logic             we_sector, we_ctrl, we_rel, start;
  logic [1:0]       rel, full_set;
  logic             rel_ovr;

  logic [31:0]      pk_word;
  logic             pk_vld, pk_done, pk_stb;
  logic [IDX_W-1:0] pk_idx;

  logic unused_ok;
  assign unused_ok = ^{wByteEnable, buf_off[31:BIDX_W+2], buf_off[1:0]};

  // Address decode; the base need not be aligned, so decode on the offset.
  assign off     = wAddress - BASE_ADDR;
  assign buf_off = off - OFF_BUF;
  assign buf_idx = buf_off[BIDX_W+1:2];
  assign reg_hit = (off[31:4] == 28'd0);
  assign buf_hit = (off >= OFF_BUF) && (off < BUF_END);

  assign we_sector = wWriteEnable && reg_hit && (off[3:2] == OFF_SECTOR[3:2]);
  assign we_ctrl   = wWriteEnable && reg_hit && (off[3:2] == OFF_CTRL[3:2]);
  assign we_rel    = wWriteEnable && reg_hit && (off[3:2] == OFF_RELEASE[3:2]);

  assign start = we_ctrl && (state_q == S_IDLE) && (wWriteData[MAX_BLOCKS_W-1:0] != '0);

  assign rel     = we_rel ? {wWriteData[REL_BANK1], wWriteData[REL_BANK0]} : 2'b00;
  assign rel_ovr = we_rel && wWriteData[REL_OVR];

  // A bank becoming full wins over a release of that same bank.
  assign full_set = pk_done ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign full_d   = (full_q & ~rel) | full_set;
  assign ovr_d    = (ovr_q & ~rel_ovr) | (iEngValid && (state_q != S_FILL));

  assign pk_stb = iEngValid && (state_q == S_FILL);

  sd_byte_packer #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .IDX_W      (IDX_W)
  ) u_packer (
    .clk_i     (iCLK),
    .rst_i     (Reset),
    .clr_i     (start),
    .stb_i     (pk_stb),
    .byte_i    (iEngByte),
    .word_o    (pk_word),
    .word_vld_o(pk_vld),
    .word_idx_o(pk_idx),
    .blk_done_o(pk_done)
  );

  always_ff @(posedge iCLK) begin
    if (pk_vld) begin
      mem_q[{bank_q, pk_idx}] <= pk_word;
    end
  end

  always_comb begin
    status_w                              = '0;
    status_w[ST_BUSY]                     = (state_q != S_IDLE);
    status_w[ST_FULL0]                    = full_q[0];
    status_w[ST_FULL1]                    = full_q[1];
    status_w[ST_OVR]                      = ovr_q;
    status_w[ST_REM_LSB +: MAX_BLOCKS_W]  = rem_q;
  end

  always_comb begin
    rdata = '0;
    if (buf_hit) begin
      rdata = mem_q[buf_idx];
    end else if (reg_hit && (off[3:2] == OFF_SECTOR[3:2])) begin
      rdata = sector_q;
    end else if (reg_hit && (off[3:2] == OFF_STATUS[3:2])) begin
      rdata = status_w;
    end
  end

  assign wReadData = (wReadEnable && (reg_hit || buf_hit)) ? rdata : 32'hzzzzzzzz;

  // Transfer sequencer; request and address are registered outputs.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      sector_q <= '0;
      rem_q    <= '0;
      bank_q   <= 1'b0;
      full_q   <= 2'b00;
      ovr_q    <= 1'b0;
      oEngRd   <= 1'b0;
      oEngAddr <= '0;
    end else begin
      full_q <= full_d;
      ovr_q  <= ovr_d;
      if (we_sector) begin
        sector_q <= wWriteData;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_ISSUE;
            rem_q    <= wWriteData[MAX_BLOCKS_W-1:0];
            bank_q   <= 1'b0;
            oEngRd   <= 1'b1;
            oEngAddr <= sector_q;
          end
        end
        S_ISSUE: begin
          if (iEngBusy) begin
            state_q <= S_FILL;
            oEngRd  <= 1'b0;
          end
        end
        S_FILL: begin
          if (pk_done) begin
            sector_q <= sector_inc(sector_q);
            rem_q    <= rem_q - MAX_BLOCKS_W'(1);
            bank_q   <= ~bank_q;
            if (rem_q == MAX_BLOCKS_W'(1)) begin
              state_q <= S_IDLE;
            end else if (full_d[~bank_q]) begin
              state_q <= S_WAIT;
            end else begin
              state_q  <= S_ISSUE;
              oEngRd   <= 1'b1;
              oEngAddr <= sector_inc(sector_q);
            end
          end
        end
        S_WAIT: begin
          if (!full_d[bank_q]) begin
            state_q  <= S_ISSUE;
            oEngRd   <= 1'b1;
            oEngAddr <= sector_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SD_BLOCK_PORT_IRQ_EN
  logic irq_q;

  // Completion coincides with the last bank-full event, so one pulse per block.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= pk_done;
    end
  end

  assign oIRQ = irq_q | ovr_q;
`endif

endmodule

// File: doc/sd_block_port.md
# sd_block_port

Memory-mapped SD-card block reader: successor to the single-block SD SPI bus interface. Sits between the processor data bus and the SD SPI byte engine (`sd_controller`). Adds programmable multi-block reads, a parametrised block size, and ping-pong double buffering so software drains one bank while the engine fills the other.

## Interface
- `BASE_ADDR`, 32'hFFFF0250: base of the register window.
- `BLOCK_WORDS`, 128: 32-bit words per block; power of two, 4..128.
- `MAX_BLOCKS_W`, 8: width of the block-count field.
- `iCLK` input 1: sole clock; engine and bus are synchronous to it.
- `Reset` input 1: synchronous, active-high.
- `wReadEnable`, `wWriteEnable` input 1: bus strobes.
- `wByteEnable` input 4: accepted; registers are full-word only.
- `wAddress`, `wWriteData` input 32: bus address and data.
- `wReadData` output 32: read data; `32'hzzzzzzzz` when not selected.
- `oEngRd` output 1: block read request to the engine.
- `oEngAddr` output 32: sector address for the current block.
- `iEngBusy` input 1: engine busy.
- `iEngByte` input 8: received byte.
- `iEngValid` input 1: one-cycle strobe; `iEngByte` is valid.

## Operation
- Registers at `BASE_ADDR`:
  - +0x00 SECTOR (RW): start sector.
  - +0x04 CTRL (W): [MAX_BLOCKS_W-1:0] = block count N; a write starts the transfer.
  - +0x08 STATUS (R): bit0 busy, bit1 bank0 full, bit2 bank1 full, bit3 overrun, bits[15:8] blocks remaining.
  - +0x0C RELEASE (W): bit0 frees bank0, bit1 frees bank1, bit3 clears overrun.
- Buffer window at +0x200: word i of bank b is at +0x200 + 4·(b·BLOCK_WORDS + i).
- Byte packing: bytes are packed little-endian; the first byte of the block lands in [7:0]. A word is committed on every 4th byte.
- FSM states and transitions:
  - IDLE: a CTRL write with N≠0 → ISSUE. N=0 and CTRL writes while busy are ignored.
  - ISSUE: assert `oEngRd` with `oEngAddr` = current sector. Hold until `iEngBusy` = 1 → FILL.
  - FILL: pack bytes into the target bank. After 4·BLOCK_WORDS bytes: set bank full, sector+1, remaining−1, toggle bank. Then: remaining = 0 → IDLE; other bank full → WAIT; otherwise → ISSUE.
  - WAIT: stay until the target bank is released, then → ISSUE.
- The first block always goes to bank0.
- Overrun: an `iEngValid` strobe outside FILL sets the overrun bit and the byte is dropped.
- Simultaneous events:
  - Release of the bank being filled is ignored.
  - A release and a bank-full event on different banks in the same cycle both take effect.
- Sector arithmetic is 32-bit modulo; 32'hFFFFFFFF wraps to 0.

## Timing
- Reset values: `oEngRd` 0, `oEngAddr` 0, `wReadData` Z, SECTOR 0, STATUS 0, FSM IDLE.
- Reset mid-transfer aborts within one cycle: `oEngRd` drops and both banks are marked empty.
- `oEngRd` rises the cycle after the CTRL write or after leaving WAIT.
- Bank full (and the STATUS bit) is visible the cycle after the last byte strobe.
- Register/buffer reads are combinational: same cycle as `wReadEnable`.
- Register writes take effect on the `iCLK` edge.

## Configuration
- `SD_BLOCK_PORT_IRQ_EN`: when defined, adds output `oIRQ` (1 bit, reset 0).
  - Pulses high one cycle whenever a bank becomes full or the transfer completes.
  - Level-holds while overrun is set.
- Without the macro: no `oIRQ` port; software polls STATUS.

## Structure
- Shared package `sd_block_pkg` holds:
  - register offsets (SECTOR, CTRL, STATUS, RELEASE, BUF);
  - STATUS bit indices;
  - FSM state enum (IDLE, ISSUE, FILL, WAIT).
- Sub-module `sd_byte_packer`: byte→word assembler.
  - Inputs: byte, strobe, clear.
  - Outputs: word, word-valid, word index.
  - Includes a block-done flag at 4·BLOCK_WORDS bytes.

## Test plan
- SECTOR=0x10, CTRL=1, model sends 512 bytes 0x00..0xFF repeating → bank0 word0 = 0x03020100, STATUS = 0x02, `oEngAddr` = 0x10, FSM back in IDLE.
- CTRL=3, no releases → two blocks fill banks 0/1, FSM holds in WAIT with remaining = 1; RELEASE=1 → third block issued at sector+2, lands in bank0.
- Byte strobe during WAIT → overrun bit set, buffer unchanged; RELEASE=0x8 clears it.
- `Reset` asserted after 100 bytes of a block → next cycle `oEngRd` = 0, STATUS = 0; new CTRL=1 starts cleanly at bank0 word0.
- SECTOR=0xFFFFFFFF, CTRL=2 → second request at sector 0x00000000; CTRL=0 and CTRL while busy → no `oEngRd` change.
- With `SD_BLOCK_PORT_IRQ_EN`, BLOCK_WORDS=4: `oIRQ` pulses exactly once per 16-byte block.
